// File: rtl/shift_right_seq.sv
// Iterative right shifter: one operand plus shift amount per request, logical or arithmetic fill.
// Optional macro SHIFT_RIGHT_FAST_STEP_EN enables 4-bit steps while at least 4 positions remain.
module shift_right_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state_reg, state_next;
   logic [WIDTH-1:0]   work_reg, work_next;
   logic [WIDTH-1:0]   out_reg, out_next;
   logic [SHAMT_W-1:0] cnt_reg, cnt_next;
   logic               mode_reg, mode_next;
   logic               fill;
   logic [WIDTH-1:0]   shr1;
`ifdef SHIFT_RIGHT_FAST_STEP_EN
   logic [WIDTH-1:0]   shr4;
`endif

   assign fill = mode_reg & work_reg[WIDTH-1];

   // Per-bit shifted views of the work register; vacated top bits take the fill bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi + 1 < WIDTH) begin : g_s1
            assign shr1[gi] = work_reg[gi+1];
         end else begin : g_f1
            assign shr1[gi] = fill;
         end
`ifdef SHIFT_RIGHT_FAST_STEP_EN
         if (gi + 4 < WIDTH) begin : g_s4
            assign shr4[gi] = work_reg[gi+4];
         end else begin : g_f4
            assign shr4[gi] = fill;
         end
`endif
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;
      out_next   = out_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               work_next = in_data;
               cnt_next  = shamt;
               mode_next = arith;
               if (shamt == '0) begin
                  state_next = DONE;
                  out_next   = in_data;
               end else begin
                  state_next = SHIFT;
               end
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
`ifdef SHIFT_RIGHT_FAST_STEP_EN
            if (cnt_reg >= SHAMT_W'(4)) begin
               work_next = shr4;
               cnt_next  = cnt_reg - SHAMT_W'(4);
            end else begin
               work_next = shr1;
               cnt_next  = cnt_reg - SHAMT_W'(1);
            end
`else
            work_next = shr1;
            cnt_next  = cnt_reg - SHAMT_W'(1);
`endif
            // Only the final value is published, so out_data never shows partial shifts.
            if (cnt_next == '0) begin
               state_next = DONE;
               out_next   = work_next;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         cnt_reg   <= '0;
         mode_reg  <= 1'b0;
         out_reg   <= '0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         cnt_reg   <= cnt_next;
         mode_reg  <= mode_next;
         out_reg   <= out_next;
      end
   end

   assign busy     = (state_reg == SHIFT);
   assign done     = (state_reg == DONE);
   assign out_data = out_reg;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: stimulus pushes expected results, a monitor checks each done pulse.
module tb_shift_right_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] in_data;
   logic [4:0]  shamt;
   logic        arith;
   logic        busy;
   logic        done;
   logic [31:0] out_data;

   typedef struct {
      logic [31:0] data;
      int          issue;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_done = 0;
   int   busy_run = 0;

   shift_right_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
      .shamt(shamt), .arith(arith), .busy(busy), .done(done), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
      logic signed [31:0] sd;
      logic [31:0] r;
      sd = d;
      if (a) r = sd >>> s;
      else   r = d >> s;
      return r;
   endfunction

   function automatic int ref_lat(input int s);
`ifdef SHIFT_RIGHT_FAST_STEP_EN
      return s / 4 + s % 4;
`else
      return s;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a);
      int w;
      exp_t e;
      w = 0;
      @(negedge clk);
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", w);
      end
      in_data = d;
      shamt   = s;
      arith   = a;
      start   = 1'b1;
      e.data  = ref_shift(d, int'(s), a);
      e.issue = cyc + 1;
      e.lat   = ref_lat(int'(s));
      sb.push_back(e);
      $display("op: in=%h shamt=%0d arith=%0b expect=%h lat=%0d", d, s, a, e.data, e.lat);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            busy_run = 0;
         end else begin
            n_cmp++;
            if (busy && done) begin
               n_bad++;
               $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both 1", busy, done);
            end
            if (busy) busy_run++;
            if (done) begin
               n_done++;
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_done: done=1 out_data=%h, required no done", out_data);
               end else begin
                  e = sb.pop_front();
                  n_cmp++;
                  if (out_data !== e.data) begin
                     n_bad++;
                     $display("FAIL result: got %h, required %h", out_data, e.data);
                  end
                  n_cmp++;
                  if (cyc - e.issue != e.lat) begin
                     n_bad++;
                     $display("FAIL latency: got %0d, required %0d", cyc - e.issue, e.lat);
                  end
                  n_cmp++;
                  if (busy_run != e.lat) begin
                     n_bad++;
                     $display("FAIL busy_cycles: got %0d, required %0d", busy_run, e.lat);
                  end
                  $display("done: out=%h expect=%h", out_data, e.data);
               end
               busy_run = 0;
            end
         end
      end
   end

   initial begin
      int w;
      int done_before;
      reset_n = 1'b0;
      start   = 1'b0;
      in_data = '0;
      shamt   = '0;
      arith   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_out", out_data, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue(32'h89018310, 5'd2, 1'b0);
      issue(32'h81234011, 5'd4, 1'b1);
      issue(32'h81234011, 5'd4, 1'b0);
      issue(32'hAAAA9999, 5'd0, 1'b0);
      issue(32'h2345F000, 5'd2, 1'b0);
      issue(32'h80000000, 5'd31, 1'b1);
      issue(32'h80000000, 5'd31, 1'b0);

      // start pulsed mid-shift with another operand must be ignored
      issue(32'h9ABCDEF0, 5'd10, 1'b1);
      @(negedge clk);
      @(negedge clk);
      in_data = 32'h12345678;
      shamt   = 5'd3;
      arith   = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      // reset mid-operation discards the in-flight request
      issue(32'hC0FFEE11, 5'd20, 1'b1);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_done", {31'd0, done}, 32'd0);
      chk("midreset_out", out_data, 32'd0);
      sb.delete();
      done_before = n_done;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midreset_no_done", n_done - done_before, 32'd0);
      chk("midreset_out_hold", out_data, 32'd0);

      for (int i = 0; i < 40; i++) begin
         issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end

      w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("drain_outstanding", sb.size(), 32'd0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
Iterative right shifter, the inverse-direction companion to the combinational left-by-2 shifter in the datapath.
- Uses: byte address -> word address conversion, and SRL/SRA execution in the multi-cycle ALU.
- Accepts one 32-bit operand plus a shift amount per request and shifts one bit position per clock.
- Reports completion with a one-cycle done pulse and a held result.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request strobe; sampled only in IDLE or DONE
in_data  input  WIDTH  operand, captured on accepted start
shamt  input  SHAMT_W  shift amount 0..WIDTH-1, captured on accepted start
arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle completion pulse
out_data  output  WIDTH  result register; holds last result until next completion

Behaviour:
- Reset: reset_n sampled low at a rising edge sets:
  - state=IDLE, busy=0, done=0, out_data=0, internal work/count/mode registers=0.
  - Applies in any state; an in-flight operation is discarded and done does not fire for it.
- States and transitions: IDLE, SHIFT, DONE.
  - IDLE + start: capture in_data into work, shamt into cnt, arith into mode.
    - Next state is SHIFT if shamt != 0, otherwise DONE.
  - SHIFT: each cycle, work is shifted right by 1 and cnt is decremented.
    - Fill bit = mode ? work[WIDTH-1] : 0.
    - When cnt == 1 at the edge, this is the last shift; next state is DONE.
  - DONE: done=1 and out_data=final work value, both updated at the edge entering DONE.
    - Next cycle: if start is high, it is accepted exactly as from IDLE (back-to-back allowed); otherwise go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle following edge k+shamt.
  - shamt=0 gives done in the cycle right after the accepting edge.
  - shamt=31 gives done after 31 shift edges.
- start while in SHIFT: ignored; no capture, no effect on the in-flight operation.
- out_data is only written on entry to DONE, so intermediate shift values never appear on it.
  - out_data stays stable through the following IDLE and through a new operation until that operation completes.
- busy = (state == SHIFT). busy and done are never high together.
- Widths: cnt is SHAMT_W bits and never wraps (it is decremented only while nonzero).
- Arithmetic shift of a negative operand by WIDTH-1 yields all ones; logical shift yields 0 or 1.

Optional Feature:
Macro: SHIFT_RIGHT_FAST_STEP_EN.
- Defined: in SHIFT, if cnt >= 4, shift by 4 and cnt -= 4; otherwise shift by 1 and cnt -= 1.
  - Fill rule is unchanged.
  - Transition to DONE happens when the step taken makes cnt reach 0.
  - Shift-cycle count becomes floor(shamt/4) + (shamt mod 4).
- Undefined: strictly 1 bit per cycle as above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Logical shift: in_data=0x89018310, shamt=2, arith=0 -> out_data=0x224060C4, done 2 cycles after the start edge, busy high for exactly 2 cycles.
- Arithmetic shift: in_data=0x81234011, shamt=4, arith=1 -> out_data=0xF8123401; same operand with arith=0 -> 0x08123401.
- Zero shift then back-to-back:
  - in_data=0xAAAA9999, shamt=0 -> out_data=0xAAAA9999 with done on the next cycle and busy never high.
  - start held high in DONE with in_data=0x2345F000, shamt=2, arith=0 -> next result 0x08D17C00.
- Maximum shift: in_data=0x80000000, shamt=31:
  - arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001.
  - Shift-cycle count: 31 by default; 10 with SHIFT_RIGHT_FAST_STEP_EN.
- Start ignored and reset mid-operation:
  - Pulse start with a different operand during SHIFT -> original result unaffected.
  - Assert reset_n=0 mid-SHIFT -> next cycle state IDLE, busy=0, done=0, out_data=0, and no done pulse afterwards.
